interval_timer: RTL and testbench
=================================

# interval_timer

Programmable interval timer and time-parameter store for the traffic light controller. It sits between the `FSM` and the 1 Hz timebase. The FSM requests an interval with `start_timer`/`interval` and receives a one-cycle `expired` pulse when that many seconds have elapsed. The block also holds the three operator-programmable durations (base, extended, yellow), which are written through `Prog_Sync`.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clk cycles per one-second tick; must be ≥ 2.
- `VAL_W`, default 4: width of a time value, in seconds.
- `DEF_BASE`, default 6: reset value of tBASE.
- `DEF_EXT`, default 3: reset value of tEXT.
- `DEF_YEL`, default 2: reset value of tYEL.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `Reset_Sync` in 1: asynchronous, active-high reset.
- `Prog_Sync` in 1: single-cycle write strobe for a time parameter.
- `Time_Parameter_Selector` in 2: parameter to write. 00 = base, 01 = extended, 10 = yellow, 11 = none.
- `Time_Value` in VAL_W: value to write, in seconds.
- `start_timer` in 1: single-cycle pulse that (re)starts a countdown.
- `interval` in 2: interval to time, sampled with `start_timer`. 00 = base, 01 = extended, 10 = yellow, 11 = base.
- `expired` out 1: one-cycle pulse when the countdown completes.
- `busy` out 1: high while a countdown is running.
- `remaining` out VAL_W: seconds left, for display/debug; 0 when idle.

## Operation
- **Parameter registers:** three registers, tBASE, tEXT and tYEL.
  - Reset loads DEF_BASE, DEF_EXT and DEF_YEL.
  - `Prog_Sync` with selector 00/01/10 writes `Time_Value` into the selected register.
  - A `Time_Value` of 0 is stored as 1.
  - Selector 11 writes nothing.
- **States:** IDLE and RUN. `expired` is a registered output, not a separate state.
- **IDLE:**
  - On `start_timer`: load `remaining` with the parameter selected by `interval`, clear the divider, go to RUN, set `busy` to 1.
- **RUN:**
  - The divider counts 0..TICK_DIV-1. The tick fires when it reaches TICK_DIV-1, and the divider wraps to 0.
  - On a tick with `remaining` > 1: decrement `remaining`.
  - On a tick with `remaining` == 1: set `remaining` to 0, go to IDLE, drop `busy` and assert `expired` for exactly one cycle.
- **Restart:** `start_timer` in RUN reloads `remaining` and clears the divider. No `expired` is produced for the abandoned interval.
- **Start and final tick together:** the restart wins and no `expired` is produced.
- **Abort on programming:** `Prog_Sync` in RUN performs the write and aborts the countdown. The block goes to IDLE with `remaining` = 0 and produces no `expired`.
- **Start and program together:** the program wins and `start_timer` is ignored.
- **Value capture:** the countdown value is captured at start, so later parameter writes never change a running interval.
- **Divider gating:** the divider runs only in RUN and is held at 0 in IDLE.
- **Reset mid-operation:** immediate return to IDLE, all outputs at their reset values, parameters back to their defaults.

## Timing
- **Reset values:** `expired` = 0, `busy` = 0, `remaining` = 0, divider = 0, tBASE/tEXT/tYEL = defaults.
- **Start latency:** with `start_timer` sampled at edge E0, `busy` = 1 and `remaining` = N are visible after E0.
- **Decrements:** `remaining` decrements after edges E0 + k·TICK_DIV, for k = 1..N-1.
- **Expiry:** `expired` is high for the single cycle following edge E0 + N·TICK_DIV. `busy` falls on the same edge.
- **Total delay:** start to expiry is exactly N·TICK_DIV cycles.
- **Back-to-back:** the FSM may pulse `start_timer` in the same cycle that `expired` is high. The new countdown begins normally.
- **Parameter writes:** take effect on the edge that samples `Prog_Sync`. The next start uses the new value.
- **Counter widths:** the divider is $clog2(TICK_DIV) bits. `remaining` is VAL_W bits and never underflows.

## Structure
- **Shared package `tlc_pkg`:**
  - Interval encodings: INT_BASE, INT_EXT, INT_YEL.
  - Selector encodings: SEL_BASE, SEL_EXT, SEL_YEL, SEL_NONE.
  - Default durations.
  - The state enum.
  - The `FSM` imports the same encodings.
- **Sub-module `tick_divider`:** has `clk`, `Reset_Sync` and `clear`, and produces a one-cycle `tick` every TICK_DIV enabled cycles. Countdown, parameter store and control stay in `interval_timer`.

## Test plan
All scenarios use TICK_DIV = 4 and defaults 6/3/2.
- **Default base interval:** reset, then `start_timer` with `interval` = 00 → `expired` pulses once, 1 cycle wide, exactly 24 cycles after start. `remaining` steps 6,5,4,3,2,1,0.
- **Programmed extended interval:** `Prog_Sync` with selector 01 and value 9, then start with `interval` 01 → `expired` at 36 cycles. Start with 11 → base interval, 24 cycles.
- **Zero value and ignored selector:** `Prog_Sync` with selector 10 and value 0 → yellow start expires at 4 cycles. `Prog_Sync` with selector 11 and value 5 → all three parameters unchanged.
- **Restart mid-run:** start 00, then start 10 ten cycles later → a single `expired`, 8 cycles after the second start. A restart in the same cycle as the final tick → no `expired` in that cycle.
- **Program mid-run:** `Prog_Sync` during RUN → `busy` = 0 and `remaining` = 0 next cycle, no `expired`, parameter written.
- **Async reset mid-run:** assert `Reset_Sync` asynchronously while counting → outputs 0 before the next clk edge, and a subsequent base start takes 24 cycles (defaults restored).

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared encodings, default durations and state type for the traffic light
// controller. The controller FSM and interval_timer both import this.
package tlc_pkg;

   // Interval requested together with start_timer (11 is treated as base)
   localparam logic [1:0] INT_BASE = 2'b00;
   localparam logic [1:0] INT_EXT  = 2'b01;
   localparam logic [1:0] INT_YEL  = 2'b10;

   // Parameter selected for a Prog_Sync write (11 writes nothing)
   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   // Power-on durations in seconds
   localparam int TLC_DEF_BASE = 6;
   localparam int TLC_DEF_EXT  = 3;
   localparam int TLC_DEF_YEL  = 2;

   // Countdown control states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_divider.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count is held at 0 whenever it is disabled or cleared, so a freshly
// started interval always sees a full TICK_DIV cycles before its first tick.
module tick_divider #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic Reset_Sync,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: hold at 0 when idle or cleared, otherwise wrap at LAST
   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Divider count register
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer plus the base/extended/yellow time-parameter
// store. A start_timer pulse captures the selected duration and counts it
// down in one-second ticks; expired pulses for one cycle when it runs out.
// Priority each cycle: Prog_Sync (write + abort) > start_timer > tick.
module interval_timer
   import tlc_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int VAL_W    = 4,
   parameter int DEF_BASE = TLC_DEF_BASE,
   parameter int DEF_EXT  = TLC_DEF_EXT,
   parameter int DEF_YEL  = TLC_DEF_YEL
) (
   input  logic             clk,
   input  logic             Reset_Sync,
   input  logic             Prog_Sync,
   input  logic [1:0]       Time_Parameter_Selector,
   input  logic [VAL_W-1:0] Time_Value,
   input  logic             start_timer,
   input  logic [1:0]       interval,
   output logic             expired,
   output logic             busy,
   output logic [VAL_W-1:0] remaining,
   output state_t           dbg_state_o
);

   state_t           state_q, state_d;
   logic [VAL_W-1:0] rem_q, rem_d;
   logic             expired_q, expired_d;
   logic [VAL_W-1:0] t_base_q, t_base_d;
   logic [VAL_W-1:0] t_ext_q, t_ext_d;
   logic [VAL_W-1:0] t_yel_q, t_yel_d;
   logic [VAL_W-1:0] wr_val;
   logic [VAL_W-1:0] start_val;
   logic             div_clear;
   logic             tick;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk        (clk),
      .Reset_Sync (Reset_Sync),
      .clear      (div_clear),
      .enable     (state_q == ST_RUN),
      .tick       (tick)
   );

   // A programmed zero would make an interval that can never tick down
   // cleanly, so it is stored as one second.
   assign wr_val = (Time_Value == '0) ? VAL_W'(1) : Time_Value;

   // Duration captured at start; interval 11 falls back to base
   always_comb begin
      start_val = t_base_q;
      case (interval)
         INT_EXT: start_val = t_ext_q;
         INT_YEL: start_val = t_yel_q;
         default: start_val = t_base_q;
      endcase
   end

   // Parameter store next-state: write the selected register on Prog_Sync
   always_comb begin
      t_base_d = t_base_q;
      t_ext_d  = t_ext_q;
      t_yel_d  = t_yel_q;
      if (Prog_Sync) begin
         case (Time_Parameter_Selector)
            SEL_BASE: t_base_d = wr_val;
            SEL_EXT:  t_ext_d  = wr_val;
            SEL_YEL:  t_yel_d  = wr_val;
            default:  ;
         endcase
      end
   end

   // Countdown FSM next-state and outputs
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      expired_d = 1'b0;
      div_clear = 1'b0;
      if (Prog_Sync) begin
         // Programming always aborts; a simultaneous start is dropped
         state_d   = ST_IDLE;
         rem_d     = '0;
         div_clear = 1'b1;
      end else if (start_timer) begin
         // Start or restart; the abandoned interval never expires
         state_d   = ST_RUN;
         rem_d     = start_val;
         div_clear = 1'b1;
      end else if (state_q == ST_RUN && tick) begin
         if (rem_q > VAL_W'(1)) begin
            rem_d = rem_q - VAL_W'(1);
         end else begin
            state_d   = ST_IDLE;
            rem_d     = '0;
            expired_d = 1'b1;
         end
      end
   end

   // Countdown state registers
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         expired_q <= expired_d;
      end
   end

   // Time-parameter registers
   always_ff @(posedge clk or posedge Reset_Sync) begin
      if (Reset_Sync) begin
         t_base_q <= VAL_W'(DEF_BASE);
         t_ext_q  <= VAL_W'(DEF_EXT);
         t_yel_q  <= VAL_W'(DEF_YEL);
      end else begin
         t_base_q <= t_base_d;
         t_ext_q  <= t_ext_d;
         t_yel_q  <= t_yel_d;
      end
   end

   assign expired     = expired_q;
   assign busy        = (state_q == ST_RUN);
   assign remaining   = rem_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_DIV = 4 and defaults 6/3/2.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge that produced them.
module tb_interval_timer;
   import tlc_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int VAL_W    = 4;
   localparam int BOUND    = 200;

   logic             clk = 1'b0;
   logic             Reset_Sync = 1'b1;
   logic             Prog_Sync = 1'b0;
   logic [1:0]       Time_Parameter_Selector = 2'b11;
   logic [VAL_W-1:0] Time_Value = '0;
   logic             start_timer = 1'b0;
   logic [1:0]       interval = 2'b00;
   logic             expired;
   logic             busy;
   logic [VAL_W-1:0] remaining;
   state_t           dbg_state;

   int checks = 0;
   int failures = 0;

   interval_timer #(
      .TICK_DIV (TICK_DIV),
      .VAL_W    (VAL_W),
      .DEF_BASE (6),
      .DEF_EXT  (3),
      .DEF_YEL  (2)
   ) dut (
      .clk                     (clk),
      .Reset_Sync              (Reset_Sync),
      .Prog_Sync               (Prog_Sync),
      .Time_Parameter_Selector (Time_Parameter_Selector),
      .Time_Value              (Time_Value),
      .start_timer             (start_timer),
      .interval                (interval),
      .expired                 (expired),
      .busy                    (busy),
      .remaining               (remaining),
      .dbg_state_o             (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             do_prog;
      logic [1:0]       sel;
      logic [VAL_W-1:0] val;
      logic [1:0]       intv;
      int               n;      // remaining right after start
      int               delay;  // cycles from start edge to expired
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // start_timer sampled on the next rising edge; returns 1 ns after it
   task automatic pulse_start(input logic [1:0] intv);
      @(negedge clk);
      start_timer = 1'b1;
      interval    = intv;
      @(posedge clk);
      #1;
      start_timer = 1'b0;
   endtask

   task automatic prog(input logic [1:0] sel, input logic [VAL_W-1:0] val, input logic with_start);
      @(negedge clk);
      Prog_Sync               = 1'b1;
      Time_Parameter_Selector = sel;
      Time_Value              = val;
      start_timer             = with_start;
      interval                = INT_BASE;
      @(posedge clk);
      #1;
      Prog_Sync   = 1'b0;
      start_timer = 1'b0;
   endtask

   // Edges until expired is seen (-1 if it never comes within BOUND)
   task automatic count_to_expiry(output int cyc);
      cyc = -1;
      for (int c = 1; c <= BOUND; c++) begin
         @(posedge clk);
         #1;
         if (expired === 1'b1) begin
            cyc = c;
            break;
         end
      end
   endtask

   initial begin
      int cyc;
      int pulses;

      vecs[0] = '{1'b0, SEL_NONE, 4'd0, INT_BASE, 6, 24};
      vecs[1] = '{1'b1, SEL_EXT,  4'd9, INT_EXT,  9, 36};
      vecs[2] = '{1'b0, SEL_NONE, 4'd0, 2'b11,    6, 24};
      vecs[3] = '{1'b1, SEL_YEL,  4'd0, INT_YEL,  1, 4};
      vecs[4] = '{1'b1, SEL_NONE, 4'd5, INT_BASE, 6, 24};
      vecs[5] = '{1'b0, SEL_NONE, 4'd0, INT_EXT,  9, 36};
      vecs[6] = '{1'b0, SEL_NONE, 4'd0, INT_YEL,  1, 4};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_expired", expired, 0);
      chk("rst_busy", busy, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      Reset_Sync = 1'b0;

      // Restart ten cycles into a base run: only the yellow run expires
      pulse_start(INT_BASE);
      pulses = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (expired === 1'b1) pulses++;
      end
      pulse_start(INT_YEL);
      chk("restart_busy", busy, 1);
      chk("restart_remaining", remaining, 2);
      count_to_expiry(cyc);
      chk("restart_no_early_expired", pulses, 0);
      chk("restart_delay", cyc, 8);

      // Restart on the final tick edge of a yellow run
      pulse_start(INT_YEL);
      pulses = 0;
      repeat (7) begin
         @(posedge clk);
         #1;
         if (expired === 1'b1) pulses++;
      end
      pulse_start(INT_BASE);
      chk("final_tick_restart_expired", expired, 0);
      chk("final_tick_restart_pre_pulses", pulses, 0);
      chk("final_tick_restart_busy", busy, 1);
      chk("final_tick_restart_remaining", remaining, 6);
      count_to_expiry(cyc);
      chk("final_tick_restart_delay", cyc, 24);

      // Programming during a run aborts it without an expiry
      pulse_start(INT_BASE);
      repeat (5) @(posedge clk);
      prog(SEL_BASE, 4'd7, 1'b0);
      chk("abort_busy", busy, 0);
      chk("abort_remaining", remaining, 0);
      chk("abort_expired", expired, 0);
      pulses = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (expired === 1'b1) pulses++;
      end
      chk("abort_no_expired", pulses, 0);
      pulse_start(INT_BASE);
      count_to_expiry(cyc);
      chk("abort_written_base_delay", cyc, 28);

      // Program and start together: program wins, start ignored
      prog(SEL_BASE, 4'd6, 1'b1);
      chk("prog_start_busy", busy, 0);
      chk("prog_start_remaining", remaining, 0);

      // Table of programming + start vectors
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_prog) prog(vecs[i].sel, vecs[i].val, 1'b0);
         pulse_start(vecs[i].intv);
         chk($sformatf("v%0d_start_busy", i), busy, 1);
         chk($sformatf("v%0d_start_remaining", i), remaining, vecs[i].n);
         cyc = -1;
         for (int c = 1; c <= BOUND; c++) begin
            @(posedge clk);
            #1;
            if (expired === 1'b1) begin
               cyc = c;
               break;
            end
            if (c % TICK_DIV == 0)
               chk($sformatf("v%0d_remaining_c%0d", i, c), remaining, vecs[i].n - c / TICK_DIV);
         end
         chk($sformatf("v%0d_delay", i), cyc, vecs[i].delay);
         chk($sformatf("v%0d_exp_busy", i), busy, 0);
         chk($sformatf("v%0d_exp_remaining", i), remaining, 0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_expired_width", i), expired, 0);
      end

      // Back-to-back: restart in the cycle expired is high (yellow is 1 s)
      pulse_start(INT_YEL);
      count_to_expiry(cyc);
      chk("b2b_first_delay", cyc, 4);
      pulse_start(INT_YEL);
      chk("b2b_busy", busy, 1);
      chk("b2b_remaining", remaining, 1);
      chk("b2b_expired_drop", expired, 0);
      count_to_expiry(cyc);
      chk("b2b_second_delay", cyc, 4);

      // Asynchronous reset mid-run restores defaults
      pulse_start(INT_EXT);
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2;
      Reset_Sync = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_remaining", remaining, 0);
      chk("async_rst_expired", expired, 0);
      @(negedge clk);
      Reset_Sync = 1'b0;
      pulse_start(INT_BASE);
      count_to_expiry(cyc);
      chk("post_rst_base_delay", cyc, 24);
      pulse_start(INT_EXT);
      count_to_expiry(cyc);
      chk("post_rst_ext_delay", cyc, 12);
      pulse_start(INT_YEL);
      count_to_expiry(cyc);
      chk("post_rst_yel_delay", cyc, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
